// File: rtl/mask_blob_tracker_pkg.sv
// Shared types for the mask blob tracker: coordinates, bounding-box slot, flush FSM states.
// Also holds the size-threshold test applied when a box is closed.
package mask_blob_tracker_pkg;

    localparam int COORD_W       = 10;
    localparam int DEF_NUM_SLOTS = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x1;
        coord_t x2;
        coord_t y1;
        coord_t y2;
        logic   valid;
    } bbox_t;

    typedef enum logic [1:0] {
        RUN,
        LINE_FLUSH,
        FRAME_FLUSH
    } state_t;

    // Width/height are inclusive extents at coordinate width; thresholds zero-extend.
    function automatic logic bbox_accept(input bbox_t b, input logic [8:0] min_x,
                                         input logic [8:0] min_y);
        coord_t w;
        coord_t h;
        w = b.x2 - b.x1 + coord_t'(1);
        h = b.y2 - b.y1 + coord_t'(1);
        return (w >= coord_t'(min_x)) && (h >= coord_t'(min_y));
    endfunction

endpackage

// File: rtl/mask_blob_tracker_blob_run_detect.sv
// Horizontal run extraction from the pixel mask stream.
// Latency: run_evt/line_end one clk after the closing pixel; no backpressure (pixel-paced).
// vs discards any open run and suppresses events from that cycle.
module blob_run_detect
    import mask_blob_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               vs,
    input  logic               mask,
    input  logic [COORD_W-1:0] tv_x,
    input  logic [COORD_W-1:0] tv_y,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    output logic               run_evt,
    output logic [COORD_W-1:0] run_x1,
    output logic [COORD_W-1:0] run_x2,
    output logic [COORD_W-1:0] run_row,
    output logic               line_end,
    output logic [COORD_W-1:0] line_row
);

    logic   in_run;
    logic   open_run;
    coord_t last_x;

    // The first column of a line always starts a fresh run.
    assign open_run = in_run && (tv_x != x_min);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_run   <= 1'b0;
            last_x   <= '0;
            run_evt  <= 1'b0;
            run_x1   <= '0;
            run_x2   <= '0;
            run_row  <= '0;
            line_end <= 1'b0;
            line_row <= '0;
        end else begin
            run_evt  <= 1'b0;
            line_end <= 1'b0;
            if (vs) begin
                in_run <= 1'b0;
            end else if (pix_en) begin
                if (tv_x == x_max) begin
                    line_end <= 1'b1;
                    line_row <= tv_y;
                end
                if (mask) begin
                    last_x <= tv_x;
                    if (!open_run) begin
                        run_x1  <= tv_x;
                        run_row <= tv_y;
                    end
                    if (tv_x == x_max) begin
                        run_evt <= 1'b1;
                        run_x2  <= tv_x;
                        in_run  <= 1'b0;
                    end else begin
                        in_run <= 1'b1;
                    end
                end else begin
                    if (open_run) begin
                        run_evt <= 1'b1;
                        run_x2  <= last_x;
                    end
                    in_run <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mask_blob_tracker.sv
// Groups mask runs into 8-connected bounding boxes held in slots, closing boxes at line/frame flush.
// Latency: slot update 1 clk after run_evt; blob_valid 1 clk after a slot is visited by a flush.
// No backpressure: blob_valid is a one-clk pulse the consumer must take.
module mask_blob_tracker
    import mask_blob_tracker_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               vs,
    input  logic               mask,
    input  logic [COORD_W-1:0] tv_x,
    input  logic [COORD_W-1:0] tv_y,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [8:0]         blob_min_x,
    input  logic [8:0]         blob_min_y,
    output logic               blob_valid,
    output logic [COORD_W-1:0] blob_x1,
    output logic [COORD_W-1:0] blob_x2,
    output logic [COORD_W-1:0] blob_y1,
    output logic [COORD_W-1:0] blob_y2,
    output logic [CNT_W-1:0]   blob_count,
    output logic [CNT_W-1:0]   frame_count,
    output logic               overflow
);

    localparam int IW = $clog2(NUM_SLOTS);

    state_t         state;
    logic [IW-1:0]  idx;
    bbox_t          slots [NUM_SLOTS];

    logic           pix_en_g;
    logic           run_evt;
    coord_t         run_x1, run_x2, run_row;
    logic           line_end;
    coord_t         line_row;

    logic           hit, free_ok;
    logic [IW-1:0]  hit_idx, free_idx;
    bbox_t          cur;
    logic           cur_ok, close_now, idx_last;

    assign pix_en_g = pix_en && (state != FRAME_FLUSH);

    blob_run_detect u_run (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en_g),
        .vs       (vs),
        .mask     (mask),
        .tv_x     (tv_x),
        .tv_y     (tv_y),
        .x_min    (x_min),
        .x_max    (x_max),
        .run_evt  (run_evt),
        .run_x1   (run_x1),
        .run_x2   (run_x2),
        .run_row  (run_row),
        .line_end (line_end),
        .line_row (line_row)
    );

    // Descending scan so the lowest-index match / free slot wins; 11-bit math avoids wrap at 0.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (slots[k].valid &&
                (11'(slots[k].y2) + 11'd1 >= 11'(run_row)) &&
                (11'(slots[k].x1) <= 11'(run_x2) + 11'd1) &&
                (11'(slots[k].x2) + 11'd1 >= 11'(run_x1))) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
            if (!slots[k].valid) begin
                free_ok  = 1'b1;
                free_idx = IW'(k);
            end
        end
    end

    assign cur       = slots[idx];
    assign cur_ok    = bbox_accept(cur, blob_min_x, blob_min_y);
    assign idx_last  = (idx == IW'(NUM_SLOTS - 1));
    assign close_now = cur.valid &&
                       ((state == FRAME_FLUSH) || (state == LINE_FLUSH && cur.y2 < line_row));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            idx         <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
            blob_valid  <= 1'b0;
            blob_x1     <= '0;
            blob_x2     <= '0;
            blob_y1     <= '0;
            blob_y2     <= '0;
            blob_count  <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            blob_valid <= 1'b0;
            if (vs) begin
                // Counters clear at entry so blobs closed by this flush count in the new frame.
                state       <= FRAME_FLUSH;
                idx         <= '0;
                frame_count <= blob_count;
                blob_count  <= '0;
                overflow    <= 1'b0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (run_evt) begin
                            if (hit) begin
                                if (run_x1 < slots[hit_idx].x1) slots[hit_idx].x1 <= run_x1;
                                if (run_x2 > slots[hit_idx].x2) slots[hit_idx].x2 <= run_x2;
                                slots[hit_idx].y2 <= run_row;
                            end else if (free_ok) begin
                                slots[free_idx] <= '{x1: run_x1, x2: run_x2, y1: run_row,
                                                     y2: run_row, valid: 1'b1};
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        if (line_end) begin
                            state <= LINE_FLUSH;
                            idx   <= '0;
                        end
                    end
                    LINE_FLUSH, FRAME_FLUSH: begin
                        if (idx_last) begin
                            state <= RUN;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    default: state <= RUN;
                endcase
                if (close_now) begin
                    slots[idx].valid <= 1'b0;
                    if (cur_ok) begin
                        blob_valid <= 1'b1;
                        blob_x1    <= cur.x1;
                        blob_x2    <= cur.x2;
                        blob_y1    <= cur.y1;
                        blob_y2    <= cur.y2;
                        if (blob_count != '1) blob_count <= blob_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mask_blob_tracker.sv
// Bench for mask_blob_tracker: frames of rectangle masks, a row-level blob model, per-emission compare.
module tb_mask_blob_tracker;

    localparam int NS = 4;
    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        vs = 1'b0;
    logic        mask = 1'b0;
    logic [9:0]  tv_x = '0, tv_y = '0, x_min = '0, x_max = '0;
    logic [8:0]  blob_min_x = '0, blob_min_y = '0;
    logic        blob_valid, overflow;
    logic [9:0]  blob_x1, blob_x2, blob_y1, blob_y2;
    logic [CW-1:0] blob_count, frame_count;

    always #5 clk = ~clk;

    mask_blob_tracker #(.NUM_SLOTS(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vs(vs), .mask(mask),
        .tv_x(tv_x), .tv_y(tv_y), .x_min(x_min), .x_max(x_max),
        .blob_min_x(blob_min_x), .blob_min_y(blob_min_y),
        .blob_valid(blob_valid), .blob_x1(blob_x1), .blob_x2(blob_x2),
        .blob_y1(blob_y1), .blob_y2(blob_y2), .blob_count(blob_count),
        .frame_count(frame_count), .overflow(overflow)
    );

    typedef struct { int x1; int x2; int y1; int y2; } rect_t;
    typedef struct { int x1; int x2; int y1; int y2; bit v; } mslot_t;
    typedef struct { int x1; int x2; int y1; int y2; int cnt; } exp_t;

    rect_t  rq[$];
    mslot_t ms[NS];
    exp_t   eq[$];
    int     m_count = 0, m_fc = 0;
    bit     m_ovf = 0;
    rect_t  m_last;
    int     errors = 0, checks = 0;
    int     xlo = 0, xhi = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit pix(input int x, input int y);
        foreach (rq[i])
            if (x >= rq[i].x1 && x <= rq[i].x2 && y >= rq[i].y1 && y <= rq[i].y2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NS; k++) ms[k] = '{0, 0, 0, 0, 1'b0};
        m_count = 0; m_fc = 0; m_ovf = 0;
        eq.delete();
        m_last = '{0, 0, 0, 0};
    endtask

    task automatic m_close(input int k);
        int w, h;
        w = ms[k].x2 - ms[k].x1 + 1;
        h = ms[k].y2 - ms[k].y1 + 1;
        ms[k].v = 1'b0;
        if (w >= int'(blob_min_x) && h >= int'(blob_min_y)) begin
            if (m_count < (1 << CW) - 1) m_count++;
            m_last = '{ms[k].x1, ms[k].x2, ms[k].y1, ms[k].y2};
            eq.push_back('{ms[k].x1, ms[k].x2, ms[k].y1, ms[k].y2, m_count});
        end
    endtask

    task automatic m_apply(input int rx1, input int rx2, input int y);
        int hit, fr;
        hit = -1; fr = -1;
        for (int k = 0; k < NS; k++) begin
            if (hit < 0 && ms[k].v && ms[k].y2 >= y - 1 && ms[k].x1 <= rx2 + 1 && ms[k].x2 >= rx1 - 1)
                hit = k;
            if (fr < 0 && !ms[k].v) fr = k;
        end
        if (hit >= 0) begin
            if (rx1 < ms[hit].x1) ms[hit].x1 = rx1;
            if (rx2 > ms[hit].x2) ms[hit].x2 = rx2;
            ms[hit].y2 = y;
        end else if (fr >= 0) begin
            ms[fr] = '{rx1, rx2, y, y, 1'b1};
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // One line: maximal masked spans left to right, then close boxes that did not grow.
    task automatic m_row(input int y);
        int x, rx1;
        x = xlo;
        while (x <= xhi) begin
            if (!pix(x, y)) begin
                x++;
            end else begin
                rx1 = x;
                while (x < xhi && pix(x + 1, y)) x++;
                m_apply(rx1, x, y);
                x++;
            end
        end
        for (int k = 0; k < NS; k++)
            if (ms[k].v && ms[k].y2 < y) m_close(k);
    endtask

    task automatic drive_row(input int y);
        for (int x = xlo; x <= xhi; x++) begin
            @(negedge clk);
            pix_en = 1'b1; tv_x = 10'(x); tv_y = 10'(y); mask = pix(x, y);
        end
        @(negedge clk);
        pix_en = 1'b0; mask = 1'b0;
        m_row(y);
        repeat (NS + 4) @(negedge clk);
    endtask

    task automatic do_vs();
        @(negedge clk);
        vs = 1'b1;
        m_fc = m_count; m_count = 0; m_ovf = 1'b0;
        for (int k = 0; k < NS; k++) if (ms[k].v) m_close(k);
        @(negedge clk);
        vs = 1'b0;
        repeat (NS + 2) @(negedge clk);
    endtask

    task automatic setup(input int xl, input int xh, input int mx, input int my);
        xlo = xl; xhi = xh; x_min = 10'(xl); x_max = 10'(xh);
        blob_min_x = 9'(mx); blob_min_y = 9'(my);
    endtask

    task automatic run_frame(input int xl, input int xh, input int yl, input int yh,
                             input int mx, input int my);
        do_vs();
        setup(xl, xh, mx, my);
        for (int y = yl; y <= yh; y++) drive_row(y);
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, " blob_count"}, int'(blob_count), m_count);
        chk({tag, " overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, " frame_count"}, int'(frame_count), m_fc);
        chk({tag, " pending blobs"}, eq.size(), 0);
    endtask

    task automatic chk_last(input string tag, input int x1, input int x2, input int y1, input int y2);
        chk({tag, " model x1"}, m_last.x1, x1);
        chk({tag, " model x2"}, m_last.x2, x2);
        chk({tag, " model y1"}, m_last.y1, y1);
        chk({tag, " model y2"}, m_last.y2, y2);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " blob_valid"}, int'(blob_valid), 0);
        chk({tag, " blob_count"}, int'(blob_count), 0);
        chk({tag, " frame_count"}, int'(frame_count), 0);
        chk({tag, " overflow"}, int'(overflow), 0);
        chk({tag, " bbox"}, int'({blob_x1, blob_x2, blob_y1, blob_y2}), 0);
    endtask

    // Every emitted box must be the next one the model predicted, with the matching count.
    always @(negedge clk) begin
        if (!rst && blob_valid) begin
            if (eq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected blob_valid: got bbox (%0d,%0d,%0d,%0d) expected none",
                         blob_x1, blob_x2, blob_y1, blob_y2);
            end else begin
                exp_t e;
                e = eq.pop_front();
                chk("emit x1", int'(blob_x1), e.x1);
                chk("emit x2", int'(blob_x2), e.x2);
                chk("emit y1", int'(blob_y1), e.y1);
                chk("emit y2", int'(blob_y2), e.y2);
                chk("emit count", int'(blob_count), e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Solid 30x20 rectangle, accepted.
        rq.delete(); rq.push_back('{100, 129, 70, 89});
        run_frame(96, 133, 70, 90, 21, 15);
        chk("t1 model count", m_count, 1);
        chk_last("t1", 100, 129, 70, 89);
        checkpoint("t1");

        // 10x10 rectangle, rejected by size.
        rq.delete(); rq.push_back('{200, 209, 100, 109});
        run_frame(196, 213, 100, 110, 21, 15);
        chk("t2 model count", m_count, 0);
        checkpoint("t2");

        // Five bars, four slots: last bar (ending at x_max) overflows; 2x5 meets thresholds exactly.
        rq.delete();
        for (int i = 0; i < 5; i++) rq.push_back('{40 + 10 * i, 41 + 10 * i, 60, 64});
        run_frame(36, 81, 60, 65, 2, 5);
        chk("t3 model count", m_count, 4);
        chk("t3 model overflow", int'(m_ovf), 1);
        checkpoint("t3");

        // Diagonal single pixels join through corners.
        rq.delete();
        for (int i = 0; i < 30; i++) rq.push_back('{50 + i, 50 + i, 80 + i, 80 + i});
        run_frame(48, 81, 80, 110, 21, 15);
        chk("t4 model count", m_count, 1);
        chk_last("t4", 50, 79, 80, 109);
        checkpoint("t4");

        // Blob still open at the bottom row; closed by the next frame flush.
        rq.delete(); rq.push_back('{150, 179, 170, 192});
        run_frame(146, 183, 170, 192, 21, 15);
        chk("t5 model frame_count", m_fc, 1);
        checkpoint("t5 open");
        do_vs();
        chk("t5 model count after flush", m_count, 1);
        chk("t5 model frame_count after flush", m_fc, 0);
        chk_last("t5", 150, 179, 170, 192);
        checkpoint("t5 flushed");

        // Reset in the middle of a blob.
        rq.delete(); rq.push_back('{300, 329, 70, 100});
        setup(296, 333, 21, 15);
        for (int y = 70; y < 80; y++) drive_row(y);
        for (int x = xlo; x <= 310; x++) begin
            @(negedge clk);
            pix_en = 1'b1; tv_x = 10'(x); tv_y = 10'd80; mask = pix(x, 80);
        end
        @(negedge clk);
        rst = 1'b1; pix_en = 1'b0; mask = 1'b0;
        #1;
        chk_zero("mid reset");
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rq.delete(); rq.push_back('{300, 329, 120, 149});
        run_frame(296, 333, 120, 150, 21, 15);
        chk("t6 model count", m_count, 1);
        chk_last("t6", 300, 329, 120, 149);
        checkpoint("t6");

        // Random rectangle sets, varying ROI and thresholds.
        for (int f = 0; f < 4; f++) begin
            int xl, xh, yl, yh, n;
            xl = 40; xh = 40 + int'($urandom_range(30, 70));
            yl = 20; yh = 20 + int'($urandom_range(10, 25));
            rq.delete();
            n = int'($urandom_range(1, 7));
            for (int i = 0; i < n; i++) begin
                int rx, ry;
                rx = xl + int'($urandom_range(0, xh - xl));
                ry = yl + int'($urandom_range(0, yh - yl));
                rq.push_back('{rx, rx + int'($urandom_range(0, 11)), ry, ry + int'($urandom_range(0, 9))});
            end
            run_frame(xl, xh, yl, yh, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            checkpoint("rand");
        end
        do_vs();
        checkpoint("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
